// File: rtl/fifo_spi_sequencer.sv
// Purpose: pops command words from a FIFO, runs one SPI transaction per word, returns read data.
// Latency: pop -> spi_start is 2 cycles; pop-to-pop is at least 4 cycles with one command in flight.
// Backpressure: no pops while enable=0 or the FIFO is empty; a read response holds in RESP until resp_ready.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   enable              allows new pops (an in-flight transaction always finishes)
//   fifo_empty          FIFO empty flag
//   fifo_rd_data        FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en          FIFO pop strobe
//   spi_start           one-cycle transaction request to the SPI master
//   spi_tx_data         command word: [DATA_WIDTH-1] write flag, [39:32] address, [31:0] write data
//   spi_done            one-cycle completion pulse, spi_rx_data valid with it
//   resp_valid/ready    read-response handshake, resp_data carries the read value
//   busy                high whenever the sequencer is not idle
//   err_timeout         sticky: a transaction saw no spi_done within TIMEOUT_CYCLES wait cycles
//   txn_count           completed transactions, wraps at 16 bits
module fifo_spi_sequencer #(
   parameter int DATA_WIDTH     = 41,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  spi_start,
   output logic [DATA_WIDTH-1:0] spi_tx_data,
   input  logic                  spi_done,
   input  logic [31:0]           spi_rx_data,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_data,
   output logic                  busy,
   output logic                  err_timeout,
   output logic [15:0]           txn_count
);

   // The wait counter only ever needs to reach TIMEOUT_CYCLES-1.
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] cmd_q;
   logic [CW-1:0]         tmo_cnt;
   logic [31:0]           resp_q;
   logic                  err_q;
   logic [15:0]           cnt_q;

   logic rd_en_c, start_c, cap_cmd, clr_tmo, inc_tmo, set_err, inc_cnt, cap_resp;
   logic wr_flag;

   // Top bit of the command word is the write flag.
   assign wr_flag = cmd_q[DATA_WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en_c   = 1'b0;
      start_c   = 1'b0;
      cap_cmd   = 1'b0;
      clr_tmo   = 1'b0;
      inc_tmo   = 1'b0;
      set_err   = 1'b0;
      inc_cnt   = 1'b0;
      cap_resp  = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !fifo_empty) begin
               rd_en_c   = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            cap_cmd   = 1'b1;
            state_nxt = START;
         end
         START: begin
            start_c   = 1'b1;
            clr_tmo   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            // A done arriving on the last allowed wait cycle still completes.
            if (spi_done) begin
               inc_cnt = 1'b1;
               if (wr_flag) begin
                  state_nxt = IDLE;
               end else begin
                  cap_resp  = 1'b1;
                  state_nxt = RESP;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               set_err   = 1'b1;
               state_nxt = IDLE;
            end else begin
               inc_tmo = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The IDLE decode alone would strobe while reset is held with a non-empty FIFO.
   assign fifo_rd_en  = rd_en_c & rst_n;
   assign spi_start   = start_c;
   assign spi_tx_data = cmd_q;
   assign resp_valid  = (state == RESP);
   assign resp_data   = resp_q;
   assign busy        = (state != IDLE);
   assign err_timeout = err_q;
   assign txn_count   = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q   <= '0;
         tmo_cnt <= '0;
         resp_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (cap_cmd)  cmd_q   <= fifo_rd_data;
         if (clr_tmo)  tmo_cnt <= '0;
         else if (inc_tmo) tmo_cnt <= tmo_cnt + 1'b1;
         if (cap_resp) resp_q  <= spi_rx_data;
         if (set_err)  err_q   <= 1'b1;
         if (inc_cnt)  cnt_q   <= cnt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_fifo_spi_sequencer.sv
module tb_fifo_spi_sequencer;

   localparam int DW = 41;
   localparam int T  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          fifo_empty;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_rd_en;
   logic          spi_start;
   logic [DW-1:0] spi_tx_data;
   logic          spi_done;
   logic [31:0]   spi_rx_data;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_data;
   logic          busy;
   logic          err_timeout;
   logic [15:0]   txn_count;

   fifo_spi_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .spi_start(spi_start),
      .spi_tx_data(spi_tx_data), .spi_done(spi_done), .spi_rx_data(spi_rx_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .busy(busy), .err_timeout(err_timeout), .txn_count(txn_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Transaction-level reference: FIFO contents, commands expected on the SPI side,
   // responses expected on the response port, and expected counters.
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_cmd[$];
   logic [31:0]   exp_resp[$];
   int            exp_count = 0;
   logic          exp_err = 1'b0;

   // SPI slave state and knobs
   bit            pend = 0;
   int            pend_cnt = 0;
   logic [31:0]   pend_rx;
   int            delay_fixed = -1;   // -1 random; 0 never answer; n answer n cycles after start
   int            rdy_fixed = -1;     // -1 random; n cycles of resp_ready=0 before accepting
   bit            use_rx_force = 0;
   logic [31:0]   rx_force;

   int            rv_run = 0;
   int            rdy_wait = 0;
   bit            prev_hs = 0;
   int            rv_total = 0;
   int            pops = 0;
   int            pushes = 0;
   int            pop_cycles[$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, actual still running, required finished");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [DW-1:0] e);
      fifo_q.push_back(e);
      exp_cmd.push_back(e);
      pushes++;
      fifo_empty = 1'b0;
   endtask

   // One clock cycle: sample outputs at negedge, act as FIFO / SPI slave / response sink.
   task automatic tick();
      logic          s_rd, s_start, s_rv;
      logic [DW-1:0] s_tx, e;
      logic [31:0]   s_rdata;
      int            d;
      @(negedge clk);
      cyc++;
      s_rd = fifo_rd_en; s_start = spi_start; s_tx = spi_tx_data;
      s_rv = resp_valid; s_rdata = resp_data;

      if (s_rd) begin
         pops++;
         pop_cycles.push_back(cyc);
         checks++;
         if (!enable || fifo_q.size() == 0) begin
            errors++;
            $display("FAIL pop_gate: fifo_rd_en=1 with enable=%0b entries=%0d, required no pop", enable, fifo_q.size());
         end
      end

      if (prev_hs) begin
         checks++;
         if (s_rv !== 1'b0) begin
            errors++;
            $display("FAIL resp_clear: resp_valid=%0b after handshake, required 0", s_rv);
         end
      end
      prev_hs = 0;

      spi_done = 1'b0;
      spi_rx_data = $urandom;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            spi_done = 1'b1;
            spi_rx_data = pend_rx;
            pend = 0;
         end
      end

      if (s_start) begin
         checks++;
         if (exp_cmd.size() == 0) begin
            errors++;
            $display("FAIL spi_start: unexpected start with tx=%h, required no start", s_tx);
         end else begin
            e = exp_cmd.pop_front();
            if (s_tx !== e) begin
               errors++;
               $display("FAIL tx_data: spi_tx_data=%h, required %h", s_tx, e);
            end
            d = (delay_fixed >= 0) ? delay_fixed : int'($urandom_range(0, T));
            pend_rx = use_rx_force ? rx_force : $urandom;
            if (d == 0) begin
               exp_err = 1'b1;
            end else begin
               pend = 1;
               pend_cnt = d;
               exp_count++;
               if (!e[DW-1]) exp_resp.push_back(pend_rx);
            end
         end
      end

      resp_ready = 1'b0;
      if (s_rv) begin
         rv_total++;
         checks++;
         if (exp_resp.size() == 0) begin
            errors++;
            $display("FAIL resp_valid: unexpected response data=%h, required none", s_rdata);
         end else if (s_rdata !== exp_resp[0]) begin
            errors++;
            $display("FAIL resp_data: resp_data=%h, required %h", s_rdata, exp_resp[0]);
         end
         if (rv_run == 0) rdy_wait = (rdy_fixed >= 0) ? rdy_fixed : int'($urandom_range(0, 3));
         if (rv_run >= rdy_wait) begin
            resp_ready = 1'b1;
            if (exp_resp.size() > 0) void'(exp_resp.pop_front());
            prev_hs = 1;
            rv_run = 0;
         end else begin
            rv_run++;
         end
      end

      @(posedge clk);
      #1;
      spi_done = 1'b0;
      if (s_rd && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((fifo_q.size() > 0 || busy || pend) && n < budget) begin
         tick();
         n++;
      end
      tick();
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain: sequencer still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; fifo_empty = 1'b0; fifo_rd_data = '0;
      spi_done = 1'b0; spi_rx_data = 32'h0; resp_ready = 1'b0;
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || spi_start !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: rd_en=%b start=%b busy=%b, required 0 0 0", fifo_rd_en, spi_start, busy);
      end
      checks++;
      if (spi_tx_data !== '0 || resp_data !== 32'h0 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: tx=%h resp=%h rv=%b, required 0", spi_tx_data, resp_data, resp_valid);
      end
      checks++;
      if (err_timeout !== 1'b0 || txn_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_status: err=%b count=%0d, required 0 0", err_timeout, txn_count);
      end
      repeat (2) @(posedge clk);
      fifo_empty = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_write();
      int p0 = pops, r0 = rv_total;
      delay_fixed = 5; rdy_fixed = 0;
      push({1'b1, 8'h10, 32'hDEADBEEF});
      drain(100);
      checks++;
      if (pops - p0 != 1) begin
         errors++;
         $display("FAIL write_pops: pops=%0d, required 1", pops - p0);
      end
      checks++;
      if (txn_count !== 16'd1) begin
         errors++;
         $display("FAIL write_count: txn_count=%0d, required 1", txn_count);
      end
      checks++;
      if (rv_total != r0) begin
         errors++;
         $display("FAIL write_noresp: resp_valid cycles=%0d, required 0", rv_total - r0);
      end
      checks++;
      if (spi_tx_data !== 41'h1_10_DEADBEEF) begin
         errors++;
         $display("FAIL write_hold: spi_tx_data=%h, required 11_0deadbeef", spi_tx_data);
      end
   endtask

   task automatic test_read();
      int r0 = rv_total;
      delay_fixed = 2; rdy_fixed = 3; use_rx_force = 1; rx_force = 32'hCAFEF00D;
      push({1'b0, 8'h20, 32'h0});
      drain(100);
      use_rx_force = 0;
      checks++;
      if (rv_total - r0 < 4) begin
         errors++;
         $display("FAIL read_hold: resp_valid cycles=%0d, required 4", rv_total - r0);
      end
      checks++;
      if (txn_count !== 16'd2 || exp_resp.size() != 0) begin
         errors++;
         $display("FAIL read_count: txn_count=%0d pending=%0d, required 2 0", txn_count, exp_resp.size());
      end
   endtask

   task automatic test_back_to_back();
      delay_fixed = 1; rdy_fixed = 0;
      pop_cycles.delete();
      for (int i = 0; i < 3; i++) push({1'b1, 8'(i + 1), $urandom});
      drain(100);
      checks++;
      if (pop_cycles.size() != 3) begin
         errors++;
         $display("FAIL b2b_pops: pops=%0d, required 3", pop_cycles.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (pop_cycles[i] - pop_cycles[i-1] != 4) begin
               errors++;
               $display("FAIL b2b_spacing: gap=%0d, required 4", pop_cycles[i] - pop_cycles[i-1]);
            end
         end
      end
      checks++;
      if (txn_count !== 16'(exp_count) || fifo_empty !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: count=%0d empty=%b busy=%b, required %0d 1 0", txn_count, fifo_empty, busy, exp_count);
      end
   endtask

   task automatic test_timeout();
      logic [15:0] c0 = txn_count;
      delay_fixed = 0;
      push({1'b0, 8'h33, 32'h0});
      repeat (3 + T - 1) tick();
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL tmo_early: err=%b busy=%b after %0d wait cycles, required 0 1", err_timeout, busy, T - 1);
      end
      tick();
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0 || txn_count !== c0) begin
         errors++;
         $display("FAIL tmo_set: err=%b busy=%b count=%0d, required 1 0 %0d", err_timeout, busy, txn_count, c0);
      end
      // Done on the last permitted wait cycle still completes the next entry.
      delay_fixed = T;
      push({1'b1, 8'h34, $urandom});
      drain(100);
      checks++;
      if (txn_count !== c0 + 16'd1 || err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL tmo_next: count=%0d err=%b, required %0d 1", txn_count, err_timeout, c0 + 16'd1);
      end
   endtask

   task automatic test_enable();
      int p0 = pops;
      logic [15:0] c0;
      enable = 1'b0;
      push({1'b1, 8'h40, $urandom});
      repeat (5) tick();
      checks++;
      if (pops != p0) begin
         errors++;
         $display("FAIL en_block: pops=%0d, required 0", pops - p0);
      end
      enable = 1'b1;
      #1;
      checks++;
      if (fifo_rd_en !== 1'b1) begin
         errors++;
         $display("FAIL en_pop: fifo_rd_en=%b, required 1", fifo_rd_en);
      end
      delay_fixed = 3;
      drain(100);
      // Dropping enable while a transaction is in flight must not stall it.
      c0 = txn_count;
      push({1'b1, 8'h41, $urandom});
      repeat (4) tick();
      enable = 1'b0;
      drain(100);
      checks++;
      if (txn_count !== c0 + 16'd1) begin
         errors++;
         $display("FAIL en_inflight: count=%0d, required %0d", txn_count, c0 + 16'd1);
      end
      enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      int p0, r0;
      delay_fixed = 6;
      push({1'b0, 8'h50, 32'h0});
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || txn_count !== 16'h0 || err_timeout !== 1'b0 || spi_tx_data !== '0) begin
         errors++;
         $display("FAIL rst_mid: busy=%b count=%0d err=%b tx=%h, required 0", busy, txn_count, err_timeout, spi_tx_data);
      end
      exp_count = 0; exp_err = 1'b0; exp_resp.delete(); exp_cmd.delete();
      rv_run = 0; prev_hs = 0;
      @(negedge clk);
      rst_n = 1'b1;
      p0 = pops; r0 = rv_total;
      pend = 1; pend_cnt = 1;   // late done arrives with the sequencer idle
      repeat (4) tick();
      checks++;
      if (txn_count !== 16'h0 || rv_total != r0 || pops != p0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_late_done: count=%0d rv=%0d pops=%0d busy=%b, required 0 0 0 0",
                  txn_count, rv_total - r0, pops - p0, busy);
      end
   endtask

   task automatic test_random();
      int sent = 0, n = 0;
      int p0 = pops, q0 = pushes;
      delay_fixed = -1; rdy_fixed = -1;
      while ((sent < 40 || fifo_q.size() > 0) && n < 3000) begin
         if (sent < 40 && fifo_q.size() < 4 && $urandom_range(0, 1) == 1) begin
            push({1'($urandom_range(0, 1)), 8'($urandom), $urandom});
            sent++;
         end
         enable = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end
      enable = 1'b1;
      drain(200);
      checks++;
      if (pops - p0 != pushes - q0) begin
         errors++;
         $display("FAIL rnd_pops: pops=%0d, required %0d", pops - p0, pushes - q0);
      end
      checks++;
      if (txn_count !== 16'(exp_count)) begin
         errors++;
         $display("FAIL rnd_count: txn_count=%0d, required %0d", txn_count, exp_count);
      end
      checks++;
      if (err_timeout !== exp_err) begin
         errors++;
         $display("FAIL rnd_err: err_timeout=%b, required %b", err_timeout, exp_err);
      end
      checks++;
      if (exp_cmd.size() != 0 || exp_resp.size() != 0) begin
         errors++;
         $display("FAIL rnd_leftover: cmds=%0d resps=%0d, required 0 0", exp_cmd.size(), exp_resp.size());
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_timeout();
      test_enable();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
